// File: rtl/imm_control_unit_if.sv
// imm_control_unit_if: instruction-control request and datapath strobe bundle.
interface imm_control_unit_if;
    logic        run;
    logic [31:0] IR;
    logic        memory_done;
    logic        PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32;
    logic        MDRout, IRin, Grb, Rout, Yin, Cout, Rin, Gra;
    logic [4:0]  opcode;
    logic        busy;
    logic [1:0]  err;
    logic [15:0] instr_count;
    modport master (
        output run, IR, memory_done,
        input  PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32,
        input  MDRout, IRin, Grb, Rout, Yin, Cout, Rin, Gra, opcode, busy, err, instr_count
    );
    modport slave (
        input  run, IR, memory_done,
        output PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32,
        output MDRout, IRin, Grb, Rout, Yin, Cout, Rin, Gra, opcode, busy, err, instr_count
    );
endinterface

// File: rtl/imm_control_unit.sv
// imm_control_unit: fetch/execute sequencer for immediate ALU instructions (addi, andi, ori).
module imm_control_unit (
    input logic                Clock,
    input logic                clear,
    imm_control_unit_if.slave  b
);
    typedef enum logic [3:0] {IDLE, T0, T1, T1W, T2, T3, T4, T5, ERR} state_t;
    state_t      state, nxt;
    logic [3:0]  wait_q;
    logic [4:0]  op_q;
    logic [15:0] cnt_q;
    logic [1:0]  err_q;
    logic        legal;
    always_comb begin
        legal = b.IR[31:27] inside {5'b00011, 5'b01011, 5'b01010};
        case (state)
            IDLE:    nxt = b.run ? T0 : IDLE;
            T0:      nxt = T1;
            T1:      nxt = b.memory_done ? T2 : T1W;
            T1W:     nxt = b.memory_done ? T2 : (wait_q == 4'hF ? ERR : T1W);
            T2:      nxt = T3;
            T3:      nxt = legal ? T4 : ERR;
            T4:      nxt = T5;
            T5:      nxt = b.run ? T0 : IDLE;
            default: nxt = ERR;
        endcase
    end
    // wait_q restarts whenever we are outside T1W, so it is zero on entry to T1
    always_ff @(posedge Clock) begin
        if (clear) begin
            state  <= IDLE;
            wait_q <= 4'd0;
            op_q   <= 5'd0;
            cnt_q  <= 16'd0;
            err_q  <= 2'b00;
        end else begin
            state  <= nxt;
            wait_q <= state == T1W ? wait_q + 4'd1 : 4'd0;
            if (state == T3) op_q <= b.IR[31:27];
            if (state == T5) cnt_q <= cnt_q + 16'd1;
            if (nxt == ERR && state != ERR) err_q <= state == T3 ? 2'b01 : 2'b10;
        end
    end
    assign b.PCout            = state == T0;
    assign b.IncPC            = state == T0;
    assign b.MARin            = state == T0;
    assign b.Zin              = state == T0 || state == T4;
    assign b.Zlo_out          = state == T1 || state == T5;
    assign b.PCin             = state == T1;
    assign b.MDRin            = state == T1 || state == T1W;
    assign b.Mem_Read         = state == T1 || state == T1W;
    assign b.Mem_enable512x32 = state == T1 || state == T1W;
    assign b.MDRout           = state == T2;
    assign b.IRin             = state == T2;
    assign b.Grb              = state == T3;
    assign b.Rout             = state == T3;
    assign b.Yin              = state == T3;
    assign b.Cout             = state == T4;
    assign b.Rin              = state == T5;
    assign b.Gra              = state == T5;
    assign b.opcode           = state == T4 ? op_q : 5'd0;
    assign b.busy             = state != IDLE && state != ERR;
    assign b.err              = err_q;
    assign b.instr_count      = cnt_q;
endmodule

// File: tb/tb_imm_control_unit.sv
// tb_imm_control_unit: randomized instruction streams checked cycle by cycle against an instruction-level model.
module tb_imm_control_unit;
    logic Clock = 1'b0;
    logic clear;
    imm_control_unit_if bus();
    imm_control_unit dut (.Clock(Clock), .clear(clear), .b(bus));
    always #5 Clock = ~Clock;

    // strobe order: PCout IncPC MARin Zin Zlo_out PCin MDRin Mem_Read Mem_enable512x32 MDRout IRin Grb Rout Yin Cout Rin Gra
    localparam logic [16:0] S_NONE = 17'b00000000000000000;
    localparam logic [16:0] S_T0   = 17'b11110000000000000;
    localparam logic [16:0] S_T1   = 17'b00001111100000000;
    localparam logic [16:0] S_T1W  = 17'b00000011100000000;
    localparam logic [16:0] S_T2   = 17'b00000000011000000;
    localparam logic [16:0] S_T3   = 17'b00000000000111000;
    localparam logic [16:0] S_T4   = 17'b00010000000000100;
    localparam logic [16:0] S_T5   = 17'b00001000000000011;

    logic [16:0] strb;
    assign strb = {bus.PCout, bus.IncPC, bus.MARin, bus.Zin, bus.Zlo_out, bus.PCin, bus.MDRin,
                   bus.Mem_Read, bus.Mem_enable512x32, bus.MDRout, bus.IRin, bus.Grb, bus.Rout,
                   bus.Yin, bus.Cout, bus.Rin, bus.Gra};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_err;
    logic [4:0]  legal_ops [3] = '{5'b00011, 5'b01011, 5'b01010};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [31:0] junk();
        return $urandom;
    endfunction

    // check the present cycle's outputs, then drive inputs for the next edge
    task automatic step(input string tag, input logic [16:0] s, input logic [4:0] op, input logic bz,
                        input logic r, input logic d, input logic [31:0] ir);
        check({tag, " strobes"}, 32'(strb), 32'(s));
        check({tag, " opcode"}, 32'(bus.opcode), 32'(op));
        check({tag, " busy"}, 32'(bus.busy), 32'(bz));
        check({tag, " err"}, 32'(bus.err), 32'(exp_err));
        check({tag, " count"}, 32'(bus.instr_count), 32'(exp_cnt));
        bus.run = r;
        bus.memory_done = d;
        bus.IR = ir;
        @(negedge Clock);
    endtask

    // one instruction starting in T0; lat = T1W cycles before memory_done, >16 means timeout
    task automatic do_instr(input logic [31:0] ir, input int lat, input logic run_after, output bit failed);
        logic [4:0] opc;
        opc = ir[31:27];
        failed = 1'b0;
        step("T0", S_T0, 5'd0, 1'b1, rb(), rb(), junk());
        step("T1", S_T1, 5'd0, 1'b1, rb(), lat == 0, junk());
        for (int k = 1; k <= lat && k <= 16; k++)
            step("T1W", S_T1W, 5'd0, 1'b1, rb(), k == lat, junk());
        if (lat > 16) begin
            exp_err = 2'b10;
            failed = 1'b1;
            return;
        end
        step("T2", S_T2, 5'd0, 1'b1, rb(), rb(), junk());
        step("T3", S_T3, 5'd0, 1'b1, rb(), rb(), ir);
        if (!(opc inside {5'b00011, 5'b01011, 5'b01010})) begin
            exp_err = 2'b01;
            failed = 1'b1;
            return;
        end
        step("T4", S_T4, opc, 1'b1, rb(), rb(), junk());
        step("T5", S_T5, 5'd0, 1'b1, run_after, rb(), junk());
        exp_cnt++;
    endtask

    task automatic start_from_idle();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) step("IDLE", S_NONE, 5'd0, 1'b0, 1'b0, rb(), junk());
        step("IDLE go", S_NONE, 5'd0, 1'b0, 1'b1, rb(), junk());
    endtask

    task automatic err_recover();
        repeat (3) step("ERR", S_NONE, 5'd0, 1'b0, rb(), rb(), junk());
        clear = 1'b1;
        step("ERR clear", S_NONE, 5'd0, 1'b0, 1'b1, 1'b1, junk());
        clear = 1'b0;
        exp_err = 2'b00;
        exp_cnt = 16'd0;
        step("after clear", S_NONE, 5'd0, 1'b0, 1'b0, rb(), junk());
    endtask

    initial begin
        bit          f;
        bit          in_t0;
        logic [4:0]  opc;
        logic        ra;
        int          lat;
        int          q;
        clear = 1'b1;
        bus.run = 1'b1;
        bus.memory_done = 1'b1;
        bus.IR = 32'h0;
        exp_cnt = 16'd0;
        exp_err = 2'b00;
        repeat (2) @(negedge Clock);
        clear = 1'b0;
        bus.run = 1'b0;
        step("reset", S_NONE, 5'd0, 1'b0, 1'b0, 1'b1, junk());
        start_from_idle();
        do_instr(32'h19A7FFFB, 0, 1'b0, f);
        start_from_idle();
        do_instr(32'h59A00053, 0, 1'b1, f);
        do_instr(32'h51A00053, 0, 1'b0, f);
        start_from_idle();
        do_instr(32'h19A7FFFB, 3, 1'b0, f);
        start_from_idle();
        do_instr(32'h19A7FFFB, 17, 1'b0, f);
        err_recover();
        start_from_idle();
        do_instr(32'hF8000000, 0, 1'b0, f);
        err_recover();
        start_from_idle();
        do_instr(32'h19A7FFFB, 1, 1'b0, f);
        start_from_idle();
        step("c T0", S_T0, 5'd0, 1'b1, 1'b1, 1'b0, junk());
        step("c T1", S_T1, 5'd0, 1'b1, 1'b1, 1'b1, junk());
        step("c T2", S_T2, 5'd0, 1'b1, 1'b1, 1'b0, junk());
        step("c T3", S_T3, 5'd0, 1'b1, 1'b1, 1'b0, 32'h19A7FFFB);
        clear = 1'b1;
        step("c T4", S_T4, 5'b00011, 1'b1, 1'b1, 1'b1, junk());
        clear = 1'b0;
        exp_cnt = 16'd0;
        step("T4 clear idle", S_NONE, 5'd0, 1'b0, 1'b0, 1'b0, junk());
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        start_from_idle();
        do_instr(32'h51A00053, 0, 1'b0, f);
        step("wrap", S_NONE, 5'd0, 1'b0, 1'b0, 1'b0, junk());
        in_t0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!in_t0) start_from_idle();
            opc = $urandom_range(0, 9) < 7 ? legal_ops[$urandom_range(0, 2)] : 5'($urandom);
            q = $urandom_range(0, 9);
            lat = q < 6 ? $urandom_range(0, 3) : q < 9 ? $urandom_range(4, 16) : 17;
            ra = i == 39 ? 1'b0 : rb();
            do_instr({opc, 27'($urandom)}, lat, ra, f);
            if (f) err_recover();
            in_t0 = !f && ra;
        end
        step("end", S_NONE, 5'd0, 1'b0, 1'b0, 1'b0, junk());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
